// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the icache, dcache and axi_ctl-facing signals of the memory port
// arbiter. Signal names match the arbiter's external port list.
//   slave  : arbiter view (cache/axi_ctl inputs in, gated/forwarded outputs out)
//   master : environment view (caches + axi_ctl), the mirror image of slave
// Port summary:
//   icache : ic_req, ic_addr -> ic_ready, ic_done, ic_data
//   dcache : dc_req, dc_rw, dc_addr, dc_fifo_{data,wen,idx,done}
//            -> dc_ready, dc_done, dc_data
//   axi_ctl: axi_ready, axi_done, axi_data_i
//            -> axi_req, axi_rw, axi_req_addr, axi_fifo_{data_o,wen,idx,done}
//   status : stage_ovf (sticky staging overflow)
interface mem_port_arbiter_if;
  logic        ic_req;
  logic [63:0] ic_addr;
  logic        ic_ready;
  logic        ic_done;
  logic [63:0] ic_data;

  logic        dc_req;
  logic        dc_rw;
  logic [63:0] dc_addr;
  logic [63:0] dc_fifo_data;
  logic        dc_fifo_wen;
  logic [8:0]  dc_fifo_idx;
  logic        dc_fifo_done;
  logic        dc_ready;
  logic        dc_done;
  logic [63:0] dc_data;

  logic        axi_ready;
  logic        axi_done;
  logic [63:0] axi_data_i;
  logic        axi_req;
  logic        axi_rw;
  logic [63:0] axi_req_addr;
  logic [63:0] axi_fifo_data_o;
  logic        axi_fifo_wen;
  logic [8:0]  axi_fifo_idx;
  logic        axi_fifo_done;

  logic        stage_ovf;

  modport slave (
    input  ic_req, ic_addr,
    input  dc_req, dc_rw, dc_addr, dc_fifo_data, dc_fifo_wen, dc_fifo_idx, dc_fifo_done,
    input  axi_ready, axi_done, axi_data_i,
    output ic_ready, ic_done, ic_data,
    output dc_ready, dc_done, dc_data,
    output axi_req, axi_rw, axi_req_addr,
    output axi_fifo_data_o, axi_fifo_wen, axi_fifo_idx, axi_fifo_done,
    output stage_ovf
  );

  modport master (
    output ic_req, ic_addr,
    output dc_req, dc_rw, dc_addr, dc_fifo_data, dc_fifo_wen, dc_fifo_idx, dc_fifo_done,
    output axi_ready, axi_done, axi_data_i,
    input  ic_ready, ic_done, ic_data,
    input  dc_ready, dc_done, dc_data,
    input  axi_req, axi_rw, axi_req_addr,
    input  axi_fifo_data_o, axi_fifo_wen, axi_fifo_idx, axi_fifo_done,
    input  stage_ovf
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single axi_ctl memory port between the icache (line refills) and
// the dcache (refills and dirty-line write-backs). Ownership is granted per
// transaction and held until the owner drops its claim; ties are broken
// round-robin. Write-back beats the dcache pushes before it owns the port are
// held in a small staging buffer and replayed (DRAIN_D) before the dcache
// gets the live port.
// Ports:
//   clk  - core clock
//   rst  - synchronous, active-high reset
//   bus  - mem_port_arbiter_if.slave (icache, dcache, axi_ctl signals)
// Parameters:
//   STAGE_DEPTH - staging buffer entries
//   RESET_PRIO  - requester favoured on the first tie after reset (1 = dcache)
module mem_port_arbiter #(
  parameter int STAGE_DEPTH = 8,
  parameter bit RESET_PRIO  = 1'b1
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int PTR_W = (STAGE_DEPTH > 1) ? $clog2(STAGE_DEPTH) : 1;
  localparam int CNT_W = $clog2(STAGE_DEPTH) + 1;
  localparam int ENT_W = 9 + 64;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWN_I   = 2'd1,
    S_OWN_D   = 2'd2,
    S_DRAIN_D = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;   // 1: dcache wins the next tie

  logic [ENT_W-1:0] stg_q [STAGE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q;

  logic ic_claim, dc_claim;
  logic ic_win, dc_win;
  logic enq_req, enq_ok, pop, full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(STAGE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Claims and arbitration
  always_comb begin
    ic_claim = bus.ic_req;
    dc_claim = bus.dc_req | bus.dc_fifo_wen;
    dc_win   = dc_claim & (~ic_claim | prio_q);
    ic_win   = ic_claim & ~dc_win;
  end

  // Staging bookkeeping: a full buffer still accepts a beat in the cycle it
  // pops one, so draining never overflows on a back-to-back live beat.
  always_comb begin
    enq_req = bus.dc_fifo_wen & (state_q != S_OWN_D);
    pop     = (state_q == S_DRAIN_D) & (count_q != '0);
    full    = (count_q == CNT_W'(STAGE_DEPTH));
    enq_ok  = enq_req & (~full | pop);
    count_d = count_q + CNT_W'(enq_ok) - CNT_W'(pop);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prio_q  <= RESET_PRIO;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Next-state logic. count_d is used (not count_q) so a beat enqueued in the
  // grant cycle itself still routes the dcache through DRAIN_D.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      S_IDLE: begin
        if (dc_win) begin
          state_d = (count_d != '0) ? S_DRAIN_D : S_OWN_D;
          prio_d  = 1'b0;
        end else if (ic_win) begin
          state_d = S_OWN_I;
          prio_d  = 1'b1;
        end
      end
      S_OWN_I:   if (!ic_claim) state_d = S_IDLE;
      S_DRAIN_D: if (count_d == '0) state_d = S_OWN_D;
      S_OWN_D:   if (!dc_claim) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    logic own_i, own_d, idle;
    own_i = (state_q == S_OWN_I);
    own_d = (state_q == S_OWN_D);
    idle  = (state_q == S_IDLE);

    bus.axi_req         = 1'b0;
    bus.axi_rw          = 1'b0;
    bus.axi_req_addr    = '0;
    bus.axi_fifo_data_o = '0;
    bus.axi_fifo_wen    = 1'b0;
    bus.axi_fifo_idx    = '0;
    bus.axi_fifo_done   = 1'b0;

    unique case (state_q)
      S_OWN_I: begin
        bus.axi_req      = bus.ic_req;
        bus.axi_req_addr = bus.ic_addr;
      end
      S_DRAIN_D: begin
        bus.axi_fifo_wen    = pop;
        bus.axi_fifo_idx    = stg_q[rd_ptr_q][ENT_W-1:64];
        bus.axi_fifo_data_o = stg_q[rd_ptr_q][63:0];
      end
      S_OWN_D: begin
        bus.axi_req         = bus.dc_req;
        bus.axi_rw          = bus.dc_rw;
        bus.axi_req_addr    = bus.dc_addr;
        bus.axi_fifo_data_o = bus.dc_fifo_data;
        bus.axi_fifo_wen    = bus.dc_fifo_wen;
        bus.axi_fifo_idx    = bus.dc_fifo_idx;
        bus.axi_fifo_done   = bus.dc_fifo_done;
      end
      default: ;
    endcase

    // In IDLE a requester may see ready unless the other side is about to win.
    bus.ic_ready  = bus.axi_ready & (own_i | (idle & ~dc_win));
    bus.dc_ready  = bus.axi_ready & (own_d | (idle & ~ic_win));
    bus.ic_done   = bus.axi_done & own_i;
    bus.dc_done   = bus.axi_done & own_d;
    bus.ic_data   = own_i ? bus.axi_data_i : '0;
    bus.dc_data   = own_d ? bus.axi_data_i : '0;
    bus.stage_ovf = ovf_q;
  end

  // Staging control
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (enq_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
      if (enq_req && !enq_ok) ovf_q <= 1'b1;
    end
  end

  // Staging storage
  always_ff @(posedge clk) begin
    if (enq_ok) stg_q[wr_ptr_q] <= {bus.dc_fifo_idx, bus.dc_fifo_data};
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single axi_ctl memory port between the instruction cache (read-only line refills) and the data cache (line refills plus dirty-line write-backs through the axi_ctl FIFO). Ownership is granted per transaction and locked until the owner releases its claim, with round-robin fairness on contention. An 8-entry staging buffer captures data-cache FIFO writes that arrive before the data cache owns the port, so no write-back beat is lost. Sits between the two caches and axi_ctl.

## Interface
- STAGE_DEPTH, 8, staging buffer entries (one 64-byte line of 64-bit beats)
- RESET_PRIO, 1, requester favoured on first contention after reset (1 = dcache, 0 = icache)

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ic_req  in  1  icache read claim; held until ic_done seen and line received
- ic_addr  in  64  icache line address
- ic_ready / ic_done  out  1  gated axi_ready / axi_done for icache
- ic_data  out  64  axi_data_i when icache owns, else 0
- dc_req, dc_rw  in  1  dcache request, direction (1 = write)
- dc_addr  in  64  dcache line address
- dc_fifo_data  in  64;  dc_fifo_wen  in  1;  dc_fifo_idx  in  9;  dc_fifo_done  in  1  dcache write-back FIFO port
- dc_ready / dc_done  out  1  gated axi_ready / axi_done for dcache
- dc_data  out  64  axi_data_i when dcache owns, else 0
- axi_ready, axi_done  in  1;  axi_data_i  in  64  from axi_ctl
- axi_req, axi_rw  out  1;  axi_req_addr  out  64  to axi_ctl
- axi_fifo_data_o  out  64;  axi_fifo_wen  out  1;  axi_fifo_idx  out  9;  axi_fifo_done  out  1  to axi_ctl
- stage_ovf  out  1  sticky staging-overflow error

## Operation
- Claims: ic_claim = ic_req; dc_claim = dc_req | dc_fifo_wen.
- States: IDLE, OWN_I, OWN_D, DRAIN_D.
- IDLE: winner = sole claimant; both claiming -> requester not last granted (pointer resets to RESET_PRIO). Next edge -> OWN_I, or DRAIN_D if staging buffer non-empty, else OWN_D. Pointer updated on grant.
- OWN_I: axi_req/axi_rw(=0)/axi_req_addr driven from icache; axi_fifo_* held 0; exit to IDLE on the edge after a cycle with ic_claim = 0.
- DRAIN_D: pops one staged beat per cycle onto axi_fifo_wen/data/idx; axi_req held 0; live dc_fifo_wen beats enqueued at tail; buffer empty -> OWN_D.
- OWN_D: all dc_* request/FIFO signals forwarded combinationally; dc_rw may change within ownership (write-back then refill); exit to IDLE when dc_claim = 0.
- Staging: any dc_fifo_wen while state != OWN_D is enqueued {idx, data}. Enqueue when full drops the beat and sets stage_ovf (cleared only by rst). dc_fifo_done forwarded only in OWN_D.
- Gating: x_ready = axi_ready & (own_x | (IDLE & !(other claims & other wins))); x_done = axi_done & own_x; non-owner data 0.

## Timing
- Reset: state IDLE, buffer empty, stage_ovf 0, pointer = RESET_PRIO; all axi_* and ic_/dc_ outputs 0.
- Grant latency: claim in IDLE cycle N -> downstream axi_req in cycle N+1 (OWN_x), or after drain (N+1+entries).
- Release: claim low in cycle M -> IDLE in M+1; earliest next grant drives axi_req in M+2 (one idle bubble).
- Simultaneous enqueue + pop in DRAIN_D: count unchanged; full + pop + enqueue accepted, no overflow.
- rst mid-transaction: ownership dropped, buffer flushed, same cycle as reset edge.
- Pointers wrap modulo STAGE_DEPTH; count width clog2(STAGE_DEPTH)+1.

## Test plan
- icache-only: ic_req=1, addr 0x8000_0040 -> axi_req=1 next cycle, addr forwarded; axi_done routed to ic_done, dc_done=0; ic_req low -> IDLE next cycle.
- Contention from reset (RESET_PRIO=1): ic_req and dc_req rise same cycle -> OWN_D first; after release, icache granted; next tie goes to dcache.
- Dirty write-back: dcache owns, 8 fifo beats idx 0..448 step 64 then dc_rw 1->0 with dc_req held -> single ownership, beats appear on axi_fifo_* in order, no IDLE between.
- Early beats: icache owns; dcache pushes 3 beats -> buffered; on grant DRAIN_D emits 3 beats in order, then OWN_D; axi_req stays 0 during drain.
- Overflow: 9 dc_fifo_wen beats while icache owns -> first 8 kept, stage_ovf=1 and stays 1 until rst.
- Reset mid OWN_D -> all outputs 0, buffer empty, next claim granted normally.
